acc_avg_periph: RTL

ACC_AVG_PERIPH -- requirements
Module: acc_avg_periph

---
 rtl/acc_avg_periph_if.sv | 13 +
 rtl/acc_avg_periph.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_avg_periph_if.sv
// Register-bus bundle for acc_avg_periph: chip enable, byte enables, address,
// write data, combinational read data and the completion interrupt.
interface acc_avg_periph_if;
  logic        ce;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output ce, we, addr, wdata, input  rdata, irq);
  modport slave  (input  ce, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/acc_avg_periph.sv
// Multi-channel accumulator/averager: per-channel running sum and sample count,
// plus one shared restoring divider that produces ACCUM/COUNT on request.
module acc_avg_periph #(
  parameter int NCH   = 4,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  acc_avg_periph_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DC_W = $clog2(ACC_W);

  localparam logic [2:0] R_CLEAR  = 3'd0;
  localparam logic [2:0] R_DATA   = 3'd1;
  localparam logic [2:0] R_ACC_LO = 3'd2;
  localparam logic [2:0] R_COUNT  = 3'd3;
  localparam logic [2:0] R_START  = 3'd4;
  localparam logic [2:0] R_AVG    = 3'd5;
  localparam logic [2:0] R_STATUS = 3'd6;
  localparam logic [2:0] R_ACC_HI = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_e;

  // Bus decode
  logic [31:0]     ch_raw;
  logic [CH_W-1:0] ch_sel;
  logic [2:0]      reg_sel;
  logic            wr, rd, wr_clear, wr_start;
  logic            unused_addr_bits;

  assign ch_raw   = bus.addr >> 5;
  assign ch_sel   = ch_raw[CH_W-1:0] & CH_W'(NCH - 1);
  assign reg_sel  = bus.addr[4:2];
  assign wr       = bus.ce && (bus.we == 4'hF);
  assign rd       = bus.ce && (bus.we == 4'h0);
  assign wr_clear = wr && (reg_sel == R_CLEAR);
  assign wr_start = wr && (reg_sel == R_START);
  assign unused_addr_bits = ^{bus.addr[1:0], ch_raw};

  // Per-channel state
  logic [ACC_W-1:0] accum_q [NCH];
  logic [ACC_W-1:0] accum_d [NCH];
  logic [CNT_W-1:0] count_q [NCH];
  logic [CNT_W-1:0] count_d [NCH];
  logic [31:0]      avg_q   [NCH];
  logic [31:0]      avg_d   [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d, avgv_q, avgv_d, dz_q, dz_d, csat_q, csat_d;

  // Divider state: quo_q starts as the dividend and fills with quotient bits
  state_e           state_q, state_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvsr_q, dvsr_d;
  logic [CH_W-1:0]  dch_q, dch_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;

  logic abort, start_go, start_zero, div_fin, irq_c;

  // One restoring-division step
  logic [CNT_W:0]   rem_sh;
  logic             q_bit;
  logic [CNT_W-1:0] rem_step;
  logic [ACC_W-1:0] quo_step;

  always_comb begin
    rem_sh   = {rem_q, quo_q[ACC_W-1]};
    q_bit    = (rem_sh >= {1'b0, dvsr_q});
    rem_step = q_bit ? CNT_W'(rem_sh - {1'b0, dvsr_q}) : CNT_W'(rem_sh);
    quo_step = {quo_q[ACC_W-2:0], q_bit};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_start) state_d = (count_q[ch_sel] == '0) ? DONE : DIV;
      DIV:     if (abort) state_d = IDLE;
               else if (dcnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a CLEAR of the channel in flight cancels result and irq
  always_comb begin
    abort      = (state_q != IDLE) && wr_clear && (ch_sel == dch_q);
    start_go   = (state_q == IDLE) && wr_start;
    start_zero = start_go && (count_q[ch_sel] == '0);
    div_fin    = (state_q == DIV) && (dcnt_q == '0) && !abort;
    irq_c      = (state_q == DONE) && !abort;
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    dch_d  = dch_q;
    dcnt_d = dcnt_q;
    if (start_go) begin
      quo_d  = accum_q[ch_sel];
      rem_d  = '0;
      dvsr_d = count_q[ch_sel];
      dch_d  = ch_sel;
      dcnt_d = DC_W'(ACC_W - 1);
    end else if (state_q == DIV) begin
      quo_d  = quo_step;
      rem_d  = rem_step;
      dcnt_d = dcnt_q - 1'b1;
    end
  end

  // Channel register updates
  logic [ACC_W:0] sum;

  always_comb begin
    sum = {1'b0, accum_q[ch_sel]} + (ACC_W + 1)'(bus.wdata);
    for (int c = 0; c < NCH; c++) begin
      accum_d[c] = accum_q[c];
      count_d[c] = count_q[c];
      avg_d[c]   = avg_q[c];
    end
    ovf_d  = ovf_q;
    avgv_d = avgv_q;
    dz_d   = dz_q;
    csat_d = csat_q;
    for (int c = 0; c < NCH; c++) begin
      if (wr && (ch_sel == CH_W'(c))) begin
        case (reg_sel)
          R_CLEAR: begin
            accum_d[c] = '0;
            count_d[c] = '0;
            avg_d[c]   = '0;
            ovf_d[c]   = 1'b0;
            avgv_d[c]  = 1'b0;
            dz_d[c]    = 1'b0;
            csat_d[c]  = 1'b0;
          end
          R_DATA: begin
            if (&count_q[c]) begin
              csat_d[c] = 1'b1;
            end else begin
              accum_d[c] = sum[ACC_W-1:0];
              count_d[c] = count_q[c] + 1'b1;
              if (sum[ACC_W]) ovf_d[c] = 1'b1;
            end
          end
          R_START: begin
            if (start_go) begin
              avgv_d[c] = 1'b0;
              dz_d[c]   = start_zero;
              if (start_zero) avg_d[c] = '0;
            end
          end
          default: ;
        endcase
      end
      // Result lands as the FSM enters DONE, so it is readable with the irq
      if (div_fin && (dch_q == CH_W'(c))) begin
        avg_d[c]  = quo_step[31:0];
        avgv_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        accum_q[c] <= '0;
        count_q[c] <= '0;
        avg_q[c]   <= '0;
      end
      ovf_q  <= '0;
      avgv_q <= '0;
      dz_q   <= '0;
      csat_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      dch_q  <= '0;
      dcnt_q <= '0;
    end else begin
      accum_q <= accum_d;
      count_q <= count_d;
      avg_q   <= avg_d;
      ovf_q   <= ovf_d;
      avgv_q  <= avgv_d;
      dz_q    <= dz_d;
      csat_q  <= csat_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dch_q   <= dch_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Zero-latency read mux
  logic [63:0] acc_wide;
  logic        busy_ch;
  logic [31:0] rdata_c;

  always_comb begin
    acc_wide = 64'(accum_q[ch_sel]);
    busy_ch  = (state_q != IDLE) && (dch_q == ch_sel);
    rdata_c  = '0;
    if (rd) begin
      case (reg_sel)
        R_ACC_LO: rdata_c = acc_wide[31:0];
        R_COUNT:  rdata_c = 32'(count_q[ch_sel]);
        R_AVG:    rdata_c = avg_q[ch_sel];
        R_STATUS: rdata_c = {27'd0, csat_q[ch_sel], dz_q[ch_sel], avgv_q[ch_sel],
                             ovf_q[ch_sel], busy_ch};
        R_ACC_HI: rdata_c = acc_wide[63:32];
        default:  rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = irq_c;
endmodule
